// File: rtl/apb_gpio_pkg.sv
// ============================================================================
// apb_gpio_pkg: register offsets and default sizing for the APB GPIO block
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_gpio_pkg;

  localparam int c_GPIO_W_DEF      = 32;
  localparam int c_SYNC_STAGES_DEF = 2;

  localparam logic [4:0] c_OFF_DATA_OUT = 5'h00;
  localparam logic [4:0] c_OFF_DIR      = 5'h04;
  localparam logic [4:0] c_OFF_DATA_IN  = 5'h08;
  localparam logic [4:0] c_OFF_IRQ_EN   = 5'h0C;
  localparam logic [4:0] c_OFF_IRQ_POL  = 5'h10;
  localparam logic [4:0] c_OFF_IRQ_STAT = 5'h14;
  localparam logic [4:0] c_OFF_OUT_SET  = 5'h18;
  localparam logic [4:0] c_OFF_OUT_CLR  = 5'h1C;

endpackage

`default_nettype wire

// File: rtl/gpio_sync_edge.sv
// ============================================================================
// gpio_sync_edge: pin synchroniser, one-cycle delay and polarity edge pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_sync_edge #(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] i_gpio,
  input  logic [GPIO_W-1:0] i_pol,
  output logic [GPIO_W-1:0] o_sync,
  output logic [GPIO_W-1:0] o_edge
);

  logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_W-1:0] r_dly;
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_dly <= '0;
    end else begin
      r_sync[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = o_sync & ~r_dly;
  assign w_fall = ~o_sync & r_dly;
  // Polarity only selects among real transitions, so rewriting it never fakes an edge.
  assign o_edge = (w_rise & i_pol) | (w_fall & ~i_pol);

endmodule

`default_nettype wire

// File: rtl/apb_gpio_ctrl.sv
// ============================================================================
// apb_gpio_ctrl: APB GPIO controller top (decode, registers, startup mask, irq)
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_gpio_ctrl
  import apb_gpio_pkg::*;
#(
  parameter int GPIO_W      = c_GPIO_W_DEF,
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [4:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [2:0] c_START_CYC = 3'(SYNC_STAGES + 1);

  logic [GPIO_W-1:0] r_data_out;
  logic [GPIO_W-1:0] r_dir;
  logic [GPIO_W-1:0] r_irq_en;
  logic [GPIO_W-1:0] r_irq_pol;
  logic [GPIO_W-1:0] r_irq_stat;
  logic              r_irq;
  logic [2:0]        r_start_cnt;

  logic              w_access;
  logic              w_aligned;
  logic              w_wr;
  logic              w_rd;
  logic              w_unmask;
  logic [GPIO_W-1:0] w_wdata;
  logic [GPIO_W-1:0] w_sync;
  logic [GPIO_W-1:0] w_edge;
  logic [GPIO_W-1:0] w_stat_clr;
  logic [GPIO_W-1:0] w_stat_set;
  logic [31:0]       w_rdata;

  gpio_sync_edge #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_gpio (gpio_in),
    .i_pol  (r_irq_pol),
    .o_sync (w_sync),
    .o_edge (w_edge)
  );

  assign w_access  = psel & penable;
  assign w_aligned = (paddr[1:0] == 2'b00);
  assign w_wr      = w_access & pwrite & w_aligned;
  assign w_rd      = w_access & ~pwrite & w_aligned;
  assign w_wdata   = pwdata[GPIO_W-1:0];

  assign pready  = w_access;
  assign pslverr = w_access & ~w_aligned;

  assign w_unmask   = (r_start_cnt == c_START_CYC);
  assign w_stat_clr = (w_wr && (paddr == c_OFF_IRQ_STAT)) ? w_wdata : '0;
  assign w_stat_set = w_unmask ? w_edge : '0;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (paddr)
        c_OFF_DATA_OUT: w_rdata[GPIO_W-1:0] = r_data_out;
        c_OFF_DIR:      w_rdata[GPIO_W-1:0] = r_dir;
        c_OFF_DATA_IN:  w_rdata[GPIO_W-1:0] = w_sync;
        c_OFF_IRQ_EN:   w_rdata[GPIO_W-1:0] = r_irq_en;
        c_OFF_IRQ_POL:  w_rdata[GPIO_W-1:0] = r_irq_pol;
        c_OFF_IRQ_STAT: w_rdata[GPIO_W-1:0] = r_irq_stat;
        default:        w_rdata = '0;
      endcase
    end
  end

  assign prdata = w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_dir       <= '0;
      r_irq_en    <= '0;
      r_irq_pol   <= '0;
      r_irq_stat  <= '0;
      r_irq       <= 1'b0;
      r_start_cnt <= '0;
    end else begin
      if (w_wr) begin
        case (paddr)
          c_OFF_DATA_OUT: r_data_out <= w_wdata;
          c_OFF_DIR:      r_dir      <= w_wdata;
          c_OFF_IRQ_EN:   r_irq_en   <= w_wdata;
          c_OFF_IRQ_POL:  r_irq_pol  <= w_wdata;
          c_OFF_OUT_SET:  r_data_out <= r_data_out | w_wdata;
          c_OFF_OUT_CLR:  r_data_out <= r_data_out & ~w_wdata;
          default:        ;
        endcase
      end
      // A fresh event beats a simultaneous write-1-to-clear on the same bit.
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_stat_set;
      r_irq      <= |(r_irq_stat & r_irq_en);
      if (!w_unmask) begin
        r_start_cnt <= r_start_cnt + 3'd1;
      end
    end
  end

  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_apb_gpio_ctrl.sv
// ============================================================================
// tb_apb_gpio_ctrl: randomized and directed bench for apb_gpio_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_gpio_ctrl;

  localparam int GPIO_W = 32;
  localparam int S      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] gpio_in = '1;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  always #5 clk = ~clk;

  apb_gpio_ctrl #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (S)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents plus a history of pin values seen at each edge.
  logic [31:0] m_out, m_dir, m_en, m_pol, m_stat;
  logic        m_irq;
  int          m_cycles;
  logic [31:0] m_hist[$];
  logic [31:0] t_sync, t_dly, t_ev, t_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_dir = '0; m_en = '0; m_pol = '0; m_stat = '0;
      m_irq = 1'b0;
      m_cycles = 0;
      m_hist.delete();
      for (int i = 0; i <= S; i++) m_hist.push_back('0);
    end else begin
      t_sync = m_hist[S-1];
      t_dly  = m_hist[S];
      t_ev   = ((t_sync & ~t_dly) & m_pol) | ((~t_sync & t_dly) & ~m_pol);
      m_cycles++;
      if (m_cycles <= S + 1) t_ev = '0;
      m_irq = |(m_stat & m_en);
      t_clr = '0;
      if (psel && penable && pwrite && paddr[1:0] == 2'b00) begin
        case (paddr)
          5'h00: m_out = pwdata;
          5'h04: m_dir = pwdata;
          5'h0C: m_en  = pwdata;
          5'h10: m_pol = pwdata;
          5'h14: t_clr = pwdata;
          5'h18: m_out = m_out | pwdata;
          5'h1C: m_out = m_out & ~pwdata;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~t_clr) | t_ev;
      m_hist.push_front(gpio_in);
      void'(m_hist.pop_back());
    end
  end

  function automatic logic [31:0] exp_prdata();
    if (!(psel && penable) || pwrite || paddr[1:0] != 2'b00) return '0;
    case (paddr)
      5'h00:   return m_out;
      5'h04:   return m_dir;
      5'h08:   return m_hist[S-1];
      5'h0C:   return m_en;
      5'h10:   return m_pol;
      5'h14:   return m_stat;
      default: return '0;
    endcase
  endfunction

  task automatic check_all();
    check_val("pready",   32'(pready),   32'(psel & penable));
    check_val("pslverr",  32'(pslverr),  32'(psel & penable & (paddr[1:0] != 2'b00)));
    check_val("prdata",   prdata,        exp_prdata());
    check_val("gpio_out", gpio_out,      m_out);
    check_val("gpio_oe",  gpio_oe,       m_dir);
    check_val("irq",      32'(irq),      32'(m_irq));
  endtask

  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    #1 check_all();
    @(negedge clk);
    penable = 1'b1;
    #1 check_all();
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      #1 check_all();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [4:0]  a;

    // Reset with all pins high, then release while writing IRQ_POL=rising.
    #2 rst_n = 1'b0;
    idle(2);
    check_val("rst_gpio_out", gpio_out, 32'h0);
    check_val("rst_gpio_oe",  gpio_oe,  32'h0);
    check_val("rst_irq",      32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h10; pwdata = '1;
    #1 check_all();
    @(negedge clk);
    penable = 1'b1;
    #1 check_all();
    idle(6);
    apb(1'b0, 5'h14, '0, rd, err);
    check_val("startup_stat", rd, 32'h0);
    apb(1'b0, 5'h08, '0, rd, err);
    check_val("startup_din", rd, 32'hFFFF_FFFF);
    // Changing polarity with stable pins must not raise status.
    apb(1'b1, 5'h10, 32'h0, rd, err);
    idle(4);
    apb(1'b0, 5'h14, '0, rd, err);
    check_val("pol_noevent", rd, 32'h0);

    // Basic write/read and set/clear aliases.
    apb(1'b1, 5'h00, 32'hA5, rd, err);
    check_val("wr_slverr", 32'(err), 32'h0);
    apb(1'b0, 5'h00, '0, rd, err);
    check_val("rd_a5", rd, 32'hA5);
    check_val("gpio_a5", gpio_out, 32'hA5);
    apb(1'b1, 5'h00, 32'hF0, rd, err);
    apb(1'b1, 5'h18, 32'h0F, rd, err);
    apb(1'b1, 5'h1C, 32'h30, rd, err);
    apb(1'b0, 5'h00, '0, rd, err);
    check_val("setclr_cf", rd, 32'hCF);
    apb(1'b0, 5'h18, '0, rd, err);
    check_val("outset_rd0", rd, 32'h0);

    // Rising edge on pin 0 with irq enabled: status at k+2, irq at k+3.
    gpio_in = '0;
    idle(4);
    apb(1'b1, 5'h14, '1, rd, err);
    apb(1'b1, 5'h0C, 32'h1, rd, err);
    apb(1'b1, 5'h10, 32'h1, rd, err);
    idle(3);
    gpio_in = 32'h1;
    idle(3);
    check_val("edge_irq_lo", 32'(irq), 32'h0);
    idle(1);
    check_val("edge_irq_hi", 32'(irq), 32'h1);
    apb(1'b0, 5'h14, '0, rd, err);
    check_val("edge_stat", rd, 32'h1);
    apb(1'b1, 5'h14, 32'h1, rd, err);
    idle(1);
    check_val("w1c_irq_hold", 32'(irq), 32'h1);
    idle(1);
    check_val("w1c_irq_clr", 32'(irq), 32'h0);

    // W1C landing on the same edge as a new event: set wins.
    gpio_in = 32'h0;
    idle(4);
    gpio_in = 32'h1;
    apb(1'b1, 5'h14, 32'h1, rd, err);
    idle(1);
    apb(1'b0, 5'h14, '0, rd, err);
    check_val("setwins_stat", rd, 32'h1);

    // Misaligned access: error, no write, zero read data.
    apb(1'b1, 5'h05, 32'hDEAD_BEEF, rd, err);
    check_val("misal_wr_err", 32'(err), 32'h1);
    apb(1'b0, 5'h02, '0, rd, err);
    check_val("misal_rd_err", 32'(err), 32'h1);
    check_val("misal_rd_data", rd, 32'h0);
    apb(1'b0, 5'h04, '0, rd, err);
    check_val("misal_dir_keep", rd, m_dir);

    // Randomized back-to-back traffic with wandering pins.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ $urandom();
      if ($urandom_range(0, 9) == 0) a = 5'($urandom());
      else                           a = {3'($urandom_range(0, 7)), 2'b00};
      apb(1'($urandom()), a, $urandom(), rd, err);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // Build up a live irq and nonzero outputs, then reset in the middle of an access.
    apb(1'b1, 5'h00, 32'h1234_5678, rd, err);
    apb(1'b1, 5'h04, 32'hFFFF_0000, rd, err);
    apb(1'b1, 5'h0C, '1, rd, err);
    apb(1'b1, 5'h10, '1, rd, err);
    gpio_in = '0;
    idle(4);
    gpio_in = '1;
    idle(5);
    check_val("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hCAFE_F00D;
    #1 check_all();
    @(negedge clk);
    penable = 1'b1;
    #1 check_all();
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_gpio_out", gpio_out, 32'h0);
    check_val("midrst_gpio_oe",  gpio_oe,  32'h0);
    check_val("midrst_irq",      32'(irq), 32'h0);
    check_val("midrst_pready",   32'(pready), 32'h1);
    check_all();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    apb(1'b0, 5'h00, '0, rd, err);
    check_val("midrst_aborted", rd, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
